uart_tx_buffered: RTL and testbench

- Serial transmitter paired with the oversampling UART receiver on the DE0-Nano-to-Raspberry Pi link.
- Accepts bytes from fabric logic through a small FIFO and serialises them on TxD as 8N1 frames.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Buffering lets a multi-byte packet be queued in a burst and sent back-to-back with no idle gap.

---
 rtl/uart_tx_buffered.sv | 141 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop
// shifter so queued bytes go out as back-to-back frames with no idle gap.
module uart_tx_buffered #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int FifoDepth    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         TxD_start,
    input  logic [7:0]                   TxD_data,
    output logic                         TxD,
    output logic                         TxD_busy,
    output logic                         TxD_full,
    output logic                         TxD_overflow,
    output logic [$clog2(FifoDepth):0]   TxD_count
);

    localparam int Div  = (ClkFrequency + Baud / 2) / Baud;
    localparam int CntW = (Div > 2) ? $clog2(Div) : 1;
    localparam int AW   = $clog2(FifoDepth);

    localparam logic [CntW-1:0] DIV_LAST = CntW'(Div - 1);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FifoDepth);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]      mem [FifoDepth];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      state;
    logic [CntW-1:0] cyc;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            push;
    logic            pop;
    logic            at_last;
    logic            not_empty;

    // Full is taken from the registered count, so a pop in the same cycle
    // never makes room for a write that arrives while full.
    assign TxD_full  = (TxD_count == FULL_CNT);
    assign not_empty = (TxD_count != '0);
    assign at_last   = (cyc == DIV_LAST);
    assign push      = TxD_start && !TxD_full;
    assign pop       = not_empty && ((state == IDLE) || (state == STOP && at_last));
    assign TxD_busy  = (state != IDLE) || not_empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= TxD_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            TxD_count    <= '0;
            TxD_overflow <= 1'b0;
        end else begin
            TxD_overflow <= TxD_start && TxD_full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   TxD_count <= TxD_count + 1'b1;
                2'b01:   TxD_count <= TxD_count - 1'b1;
                default: TxD_count <= TxD_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TxD     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    TxD <= 1'b1;
                    cyc <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        TxD   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (at_last) begin
                        cyc     <= '0;
                        TxD     <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (at_last) begin
                        cyc <= '0;
                        if (bit_idx == 3'd7) begin
                            TxD   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            TxD     <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (at_last) begin
                        cyc <= '0;
                        // Chain straight into the next start bit when bytes are waiting.
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            TxD   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TxD   <= 1'b1;
                    cyc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at DIV=10: a line receiver checks bytes against
// a scoreboard queue while directed sequences check FIFO and timing corners.
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD;
    logic       TxD_busy;
    logic       TxD_full;
    logic       TxD_overflow;
    logic [2:0] TxD_count;

    uart_tx_buffered #(.ClkFrequency(1000000), .Baud(100000), .FifoDepth(4)) dut (
        .clk(clk), .rst(rst), .TxD_start(TxD_start), .TxD_data(TxD_data),
        .TxD(TxD), .TxD_busy(TxD_busy), .TxD_full(TxD_full),
        .TxD_overflow(TxD_overflow), .TxD_count(TxD_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [7:0] sb [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Line receiver sampling mid-bit on the falling clock edge.
    bit         mon_act = 0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte;
    always @(negedge clk) begin
        if (rst) begin
            mon_act = 0;
        end else if (!mon_act) begin
            if (TxD === 1'b0) begin
                mon_act = 1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 5) begin
                chk("mon_start_bit", int'(TxD), 0);
            end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                mon_byte[3'((mon_cnt - 15) / 10)] = TxD;
            end else if (mon_cnt == 95) begin
                chk("mon_stop_bit", int'(TxD), 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_frame: got 0x%0h expected no frame", mon_byte);
                end else begin
                    chk("mon_byte", int'(mon_byte), int'(sb.pop_front()));
                end
                mon_act = 0;
            end
        end
    end

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (TxD_busy && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", int'(TxD_busy), 0);
    endtask

    task automatic wait_until(input int t);
        while (cyc_n < t) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [7:0] din;
        int         cnt_acc;
        int         cnt_next;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int t0, t_end, errs, lows;
        int exp_b;
        int burst_cnt [5];
        int s4_cnt [6];
        int s4_ovf [6];
        logic [7:0] a5;

        burst_cnt = '{1, 1, 2, 3, 4};
        s4_cnt    = '{1, 2, 3, 4, 4, 4};
        s4_ovf    = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 10; i++) vecs[i] = '{din: 8'(i), cnt_acc: 1, cnt_next: 0};

        rst = 1'b1; TxD_start = 1'b0; TxD_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", int'(TxD), 1);
        chk("rst_busy", int'(TxD_busy), 0);
        chk("rst_full", int'(TxD_full), 0);
        chk("rst_ovf", int'(TxD_overflow), 0);
        chk("rst_count", int'(TxD_count), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single byte 0xA5: exact waveform and busy release.
        a5 = 8'hA5;
        sb.push_back(a5);
        TxD_start = 1'b1; TxD_data = a5;
        @(posedge clk); #1;
        TxD_start = 1'b0;
        chk("a5_accept_txd", int'(TxD), 1);
        chk("a5_accept_count", int'(TxD_count), 1);
        errs = 0; lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i < 10) exp_b = 0;
            else if (i < 90) exp_b = int'(a5[3'((i - 10) / 10)]);
            else exp_b = 1;
            if (int'(TxD) != exp_b) errs++;
            if (!TxD_busy) lows++;
        end
        chk("a5_wave", errs, 0);
        chk("a5_busy_during", lows, 0);
        @(posedge clk); #1;
        chk("a5_busy_end", int'(TxD_busy), 0);
        chk("a5_txd_end", int'(TxD), 1);
        repeat (5) @(posedge clk);
        #1;

        // Burst of five bytes: all accepted, contiguous 500-cycle train.
        t0 = 0;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(8'(k + 1));
            TxD_start = 1'b1; TxD_data = 8'(k + 1);
            @(posedge clk); #1;
            chk("burst_count", int'(TxD_count), burst_cnt[k]);
            if (k == 1) begin
                chk("burst_first_low", int'(TxD), 0);
                t0 = cyc_n;
            end
        end
        TxD_start = 1'b0;
        chk("burst_full", int'(TxD_full), 1);
        chk("burst_no_ovf", int'(TxD_overflow), 0);
        wait_idle(700);
        t_end = cyc_n;
        chk("burst_span", t_end - t0, 500);
        chk("burst_sb_empty", sb.size(), 0);
        repeat (5) @(posedge clk);
        #1;

        // Six writes mid-frame, then a refused write on the stop-bit pop edge.
        sb.push_back(8'h10);
        TxD_start = 1'b1; TxD_data = 8'h10;
        @(posedge clk); #1;
        TxD_start = 1'b0;
        @(posedge clk); #1;
        chk("s4_start_low", int'(TxD), 0);
        t0 = cyc_n;
        wait_until(t0 + 20);
        for (int k = 0; k < 6; k++) begin
            TxD_start = 1'b1; TxD_data = 8'(8'h20 + k);
            if (k < 4) sb.push_back(8'(8'h20 + k));
            @(posedge clk); #1;
            chk("s4_count", int'(TxD_count), s4_cnt[k]);
            chk("s4_ovf", int'(TxD_overflow), s4_ovf[k]);
        end
        TxD_start = 1'b0;
        @(posedge clk); #1;
        chk("s4_ovf_clear", int'(TxD_overflow), 0);
        chk("s4_full", int'(TxD_full), 1);
        wait_until(t0 + 99);
        TxD_start = 1'b1; TxD_data = 8'h99;
        @(posedge clk); #1;
        TxD_start = 1'b0;
        chk("s5_ovf", int'(TxD_overflow), 1);
        chk("s5_count", int'(TxD_count), 3);
        chk("s5_next_start", int'(TxD), 0);
        @(posedge clk); #1;
        chk("s5_ovf_clear", int'(TxD_overflow), 0);
        wait_idle(2000);
        chk("s4_sb_empty", sb.size(), 0);
        repeat (5) @(posedge clk);
        #1;

        // Reset during data bit 3 with two bytes queued.
        TxD_start = 1'b1; TxD_data = 8'h33;
        @(posedge clk); #1;
        TxD_data = 8'h44;
        @(posedge clk); #1;
        t0 = cyc_n;
        TxD_data = 8'h55;
        @(posedge clk); #1;
        TxD_start = 1'b0;
        chk("rst_mid_count_pre", int'(TxD_count), 2);
        wait_until(t0 + 43);
        rst = 1'b1;
        #1;
        chk("rst_mid_txd", int'(TxD), 1);
        chk("rst_mid_count", int'(TxD_count), 0);
        chk("rst_mid_busy", int'(TxD_busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!TxD || TxD_busy) lows++;
        end
        chk("rst_mid_quiet", lows, 0);

        // Pointer wrap: ten single bytes, each sent from idle.
        foreach (vecs[i]) begin
            sb.push_back(vecs[i].din);
            TxD_start = 1'b1; TxD_data = vecs[i].din;
            @(posedge clk); #1;
            TxD_start = 1'b0;
            chk("wrap_count_acc", int'(TxD_count), vecs[i].cnt_acc);
            @(posedge clk); #1;
            chk("wrap_start_low", int'(TxD), 0);
            chk("wrap_count_pop", int'(TxD_count), vecs[i].cnt_next);
            wait_idle(200);
            @(posedge clk); #1;
        end
        chk("wrap_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
